// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - D-stage hazard detection, forward selects and HI/LO busy tracking
module hazard_fwd_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_md_use,
  input  logic       d_md_start,
  input  logic       d_md_div,
  output logic       stall,
  output logic [1:0] rsd_sel,
  output logic [1:0] rtd_sel,
  output logic       md_busy
);

  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] rs_res, rt_res;
  logic       data_stall, md_stall;

  // Returns {stall, sel} for one source operand; only the youngest match counts.
  function automatic logic [2:0] resolve(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ea3,
    input logic [1:0] etn,
    input logic [4:0] ma3,
    input logic [1:0] mtn,
    input logic [4:0] wa3
  );
    logic       hit;
    logic [1:0] tn;
    logic [1:0] sel;
    hit = 1'b0;
    tn  = 2'd0;
    sel = 2'b00;
    if (ea3 != 5'd0 && ea3 == src) begin
      hit = 1'b1; tn = etn; sel = 2'b11;
    end else if (ma3 != 5'd0 && ma3 == src) begin
      hit = 1'b1; tn = mtn; sel = 2'b01;
    end else if (wa3 != 5'd0 && wa3 == src) begin
      hit = 1'b1; tn = 2'd0; sel = 2'b10;
    end
    if (!hit || tn != 2'd0) sel = 2'b00;
    return {hit && (tuse != 2'd3) && (tn > tuse), sel};
  endfunction

  always_comb begin
    rs_res     = resolve(d_rs, d_rs_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    rt_res     = resolve(d_rt, d_rt_tuse, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    data_stall = rs_res[2] | rt_res[2];
    md_stall   = d_md_use && (cnt_q != 4'd0);
    stall      = data_stall | md_stall;
    rsd_sel    = rs_res[1:0];
    rtd_sel    = rt_res[1:0];
    md_busy    = (cnt_q != 4'd0);
  end

  always_comb begin
    w_a3_d   = m_a3_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    e_a3_d   = stall ? 5'd0 : d_a3;
    e_tnew_d = stall ? 2'd0 : d_tnew;
    cnt_d    = cnt_q;
    if (!stall && d_md_start)
      cnt_d = d_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
      cnt_q    <= 4'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - self-checking bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall, md_busy;
  logic [1:0] rsd_sel, rtd_sel;

  int checks   = 0;
  int failures = 0;

  // Model: in-flight instructions by age (0=E, 1=M, 2=W) with their tnew at E entry.
  int pa3[3];
  int ptn[3];
  int cyc     = 0;
  int md_done = 0;
  int exp_stall, exp_rs, exp_rt, exp_busy;

  hazard_fwd_unit #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_a3(d_a3), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .rsd_sel(rsd_sel), .rtd_sel(rtd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic int eff_tnew(int s);
    if (s == 2) return 0;
    return (ptn[s] - s > 0) ? ptn[s] - s : 0;
  endfunction

  task automatic model_op(input int x, input int tuse, output int sel, output int st);
    sel = 0;
    st  = 0;
    for (int s = 0; s < 3; s++) begin
      if (pa3[s] != 0 && pa3[s] == x) begin
        if (eff_tnew(s) == 0) sel = (s == 0) ? 3 : (s == 1) ? 1 : 2;
        st = (tuse != 3 && eff_tnew(s) > tuse) ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic model_eval();
    int s_rs, s_rt;
    model_op(int'(d_rs), int'(d_rs_tuse), exp_rs, s_rs);
    model_op(int'(d_rt), int'(d_rt_tuse), exp_rt, s_rt);
    exp_busy  = (cyc < md_done) ? 1 : 0;
    exp_stall = (s_rs | s_rt | (d_md_use && exp_busy)) ? 1 : 0;
  endtask

  task automatic model_clock();
    if (reset) begin
      for (int s = 0; s < 3; s++) begin pa3[s] = 0; ptn[s] = 0; end
      md_done = 0;
    end else begin
      pa3[2] = pa3[1]; ptn[2] = ptn[1];
      pa3[1] = pa3[0]; ptn[1] = ptn[0];
      pa3[0] = exp_stall ? 0 : int'(d_a3);
      ptn[0] = exp_stall ? 0 : int'(d_tnew);
      if (!exp_stall && d_md_start) md_done = cyc + 1 + (d_md_div ? DIV_N : MULT_N);
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_d(input int rs, input int rst, input int rt, input int rtt,
                       input int a3, input int tn, input int mu, input int ms, input int md);
    d_rs = 5'(rs); d_rs_tuse = 2'(rst); d_rt = 5'(rt); d_rt_tuse = 2'(rtt);
    d_a3 = 5'(a3); d_tnew = 2'(tn);
    d_md_use = mu[0]; d_md_start = ms[0]; d_md_div = md[0];
    #2;
  endtask

  task automatic expect_now(input string tag, input int st, input int rs, input int rt, input int b);
    chk({tag, ".stall"}, stall, 4'(st));
    chk({tag, ".rsd"}, {2'b00, rsd_sel}, 4'(rs));
    chk({tag, ".rtd"}, {2'b00, rtd_sel}, 4'(rt));
    chk({tag, ".busy"}, {3'b000, md_busy}, 4'(b));
  endtask

  task automatic step(input string tag);
    model_eval();
    chk({tag, ".m_stall"}, {3'b000, stall}, 4'(exp_stall));
    chk({tag, ".m_rsd"}, {2'b00, rsd_sel}, 4'(exp_rs));
    chk({tag, ".m_rtd"}, {2'b00, rtd_sel}, 4'(exp_rt));
    chk({tag, ".m_busy"}, {3'b000, md_busy}, 4'(exp_busy));
    @(posedge clk);
    #1;
    model_clock();
  endtask

  initial begin
    reset = 1'b1;
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_clock();

    set_d(8, 1, 0, 3, 0, 0, 0, 0, 0);
    expect_now("rst_state", 0, 0, 0, 0);
    step("rst_state");
    reset = 1'b0;

    set_d(8, 1, 0, 3, 0, 0, 0, 0, 0);
    expect_now("empty", 0, 0, 0, 0);
    step("empty");

    set_d(0, 3, 0, 3, 8, 2, 0, 0, 0);
    step("lw");
    set_d(8, 0, 0, 3, 0, 0, 0, 0, 0);
    expect_now("lw_use1", 1, 0, 0, 0);
    step("lw_use1");
    expect_now("lw_use2", 1, 0, 0, 0);
    step("lw_use2");
    expect_now("lw_use3", 0, 2, 0, 0);
    step("lw_use3");

    set_d(0, 3, 0, 3, 9, 1, 0, 0, 0);
    step("addu");
    set_d(0, 3, 9, 1, 0, 0, 0, 0, 0);
    expect_now("addu_e", 0, 0, 0, 0);
    step("addu_e");
    expect_now("addu_m", 0, 0, 1, 0);
    step("addu_m");

    set_d(0, 3, 0, 3, 31, 0, 0, 0, 0);
    step("jal");
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 0);
    expect_now("jr_e", 0, 3, 0, 0);
    set_d(0, 0, 0, 3, 0, 0, 0, 0, 0);
    expect_now("jr_r0", 0, 0, 0, 0);
    step("jr_r0");
    expect_now("jr_r0_e0", 0, 0, 0, 0);
    step("jr_r0_e0");

    set_d(0, 3, 0, 3, 5, 1, 0, 0, 0);
    step("w5a");
    step("w5b");
    set_d(5, 0, 0, 3, 0, 0, 0, 0, 0);
    expect_now("two_w5", 1, 0, 0, 0);
    step("two_w5");
    set_d(0, 3, 0, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("flush");

    set_d(0, 3, 0, 3, 0, 0, 1, 1, 1);
    step("div");
    set_d(0, 3, 0, 3, 0, 0, 1, 0, 0);
    for (int i = 1; i <= DIV_N; i++) begin
      expect_now($sformatf("mfhi_c%0d", i), 1, 0, 0, 1);
      step("mfhi");
    end
    expect_now("mfhi_c11", 0, 0, 0, 0);
    step("mfhi_c11");

    set_d(0, 3, 0, 3, 0, 0, 1, 1, 1);
    step("div2");
    set_d(0, 3, 0, 3, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) step("mfhi2");
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    expect_now("post_reset", 0, 0, 0, 0);
    step("post_reset");

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
      step("rand");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Decode-stage hazard and forwarding controller for the 5-stage MIPS pipeline.
- Tracks the destination register and Tnew of every in-flight instruction in E, M and W.
- Produces the 2-bit forward selects consumed by the D-stage RS/RT operand muxes, plus the pipeline stall.
- Includes a HI/LO busy counter for the multi-cycle mult/div unit.

Parameters:
- MULT_CYC, 5, cycles the mult unit stays busy after a mult* enters E
- DIV_CYC, 10, cycles the div unit stays busy after a div* enters E

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- d_rs  input  5  RS address of the D-stage instruction
- d_rt  input  5  RT address of the D-stage instruction
- d_rs_tuse  input  2  cycles until RS is needed (0..2); 3 = RS not used
- d_rt_tuse  input  2  cycles until RT is needed (0..2); 3 = RT not used
- d_a3  input  5  destination register of the D-stage instruction; 0 = no write
- d_tnew  input  2  Tnew the instruction carries on entering E (0..2)
- d_md_use  input  1  D instruction reads/writes HI/LO or is mult/div
- d_md_start  input  1  D instruction is mult/div
- d_md_div  input  1  with d_md_start: 1 = div, 0 = mult
- stall  output  1  freeze PC and IF/ID; bubble into ID/EX
- rsd_sel  output  2  RS forward select
- rtd_sel  output  2  RT forward select
- md_busy  output  1  mult/div counter nonzero

Behaviour:
- Select encoding:
  - 2'b00 register file
  - 2'b01 M-stage ALU result
  - 2'b10 W-stage writeback mux
  - 2'b11 E-stage operand (value already known in E, e.g. link/lui)
- Internal state:
  - slots E, M, W, each {a3[4:0], tnew[1:0]}
  - busy counter cnt[3:0]
- Reset (reset=1 at posedge): all slot a3=0, tnew=0, cnt=0. Outputs are combinational from state and inputs, so after reset stall=0, rsd_sel=rtd_sel=00 and md_busy=0 for any D inputs. Reset mid-operation discards all in-flight tracking and the busy count in the same edge.
- Advance each posedge (reset=0):
  - W <= M.
  - M <= {E.a3, E.tnew==0 ? 0 : E.tnew-1}, saturating at 0.
  - E <= stall ? {0,0} (bubble) : {d_a3, d_tnew}.
  - W tnew is always treated as 0.
- Match rule (per source operand X = rs or rt):
  - Stage S matches when S.a3 != 0 and S.a3 == d_X.
  - Only the youngest matching stage is considered; priority E, then M, then W.
  - Register 0 never matches.
- Forward select:
  - If the youngest match has tnew==0: sel = 11 for E, 01 for M, 10 for W.
  - Otherwise, or if there is no match: sel = 00. A later-stage unit handles re-forwarding when tnew <= tuse.
- Data stall: youngest match has tnew > d_X_tuse, with tuse==3 never stalling. rs and rt are evaluated independently and ORed.
- MD stall: d_md_use=1 and cnt != 0.
- stall = data stall OR MD stall.
- Busy counter:
  - If stall=0 and d_md_start=1: cnt <= d_md_div ? DIV_CYC : MULT_CYC. Load has priority over decrement.
  - Else if cnt != 0: cnt <= cnt-1.
  - While stalled, d_md_start is not loaded; the instruction remains in D.
- md_busy = (cnt != 0).
- Latency:
  - stall and sels are zero-cycle combinational from current D inputs and state.
  - Slot and counter updates take effect one clock later.

Test Plan:
- Reset, then hold d_rs=8, tuse=1, with all slots empty -> stall=0, rsd_sel=00, md_busy=0.
- lw $8 (d_a3=8, d_tnew=2) advances, next D has d_rs=8, rs_tuse=0 -> stall=1 for 2 cycles (E.tnew=2, then M.tnew=1); third cycle rsd_sel=10 (W), stall=0.
- addu $9 (tnew=1) advances, next D has d_rt=9, rt_tuse=1 -> stall=0, rtd_sel=00. One instruction later (9 in M, tnew 0) with d_rt=9 -> rtd_sel=01.
- jal (d_a3=31, tnew=0) advances, next D is jr $31 with tuse=0 -> rsd_sel=11, stall=0. Same D with d_rs=0 and an E slot a3=0 -> rsd_sel=00.
- Two writers to $5 in E (tnew 1) and M (tnew 0), d_rs=5, tuse=0 -> stall=1 (youngest E wins), M value not forwarded.
- div issued (d_md_start=1, d_md_div=1), next D is mfhi (d_md_use=1) -> md_busy=1 and stall=1 for exactly 10 cycles, stall=0 on cycle 11. Assert reset during cycle 4 -> md_busy=0, stall=0 after that edge.
